system_cmd_ctrl: RTL and testbench
==================================

# system_cmd_ctrl

Parametrised frame-level command controller for the processing unit, sitting between the synchronised UART RX byte stream and the register file/ALU datapath in the reference clock domain. Parses multi-byte command frames, sequences register-file and ALU operations, and queues response bytes in an internal FIFO drained through a valid/ready handshake toward the TX synchroniser. Successor to the fixed-width control FSM: generalised in data width, address width and response depth, with double-width ALU results, response buffering and an optional frame timeout.

## Interface
- WIDTH, 8, data/byte width; all frame fields are WIDTH bits
- ADDR_W, 4, register-file address width; address field uses the low ADDR_W bits of the byte
- FIFO_DEPTH, 8, response FIFO entries; power of two, ≥2
- TIMEOUT_CYC, 1024, idle cycles before an incomplete frame is abandoned (used only with timeout enabled)
- FUNC_W, 4, ALU function code width; low FUNC_W bits of the function byte

- i_clk  in  1  reference clock
- i_rst  in  1  asynchronous, active-low reset
- i_rx_data  in  WIDTH  received byte (already synchronised)
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- o_rf_wr_en  out  1  register-file write strobe
- o_rf_rd_en  out  1  register-file read strobe
- o_rf_addr  out  ADDR_W  register-file address
- o_rf_wdata  out  WIDTH  register-file write data
- i_rf_rdata  in  WIDTH  register-file read data
- i_rf_rvalid  in  1  read data valid strobe
- o_alu_en  out  1  ALU start strobe (operands in registers 0 and 1)
- o_alu_func  out  FUNC_W  ALU function code
- i_alu_result  in  2*WIDTH  ALU result
- i_alu_valid  in  1  ALU result valid strobe
- o_tx_data  out  WIDTH  response byte (FIFO head)
- o_tx_valid  out  1  FIFO non-empty
- i_tx_ready  in  1  consumer accepts head byte this cycle
- o_busy  out  1  state not IDLE
- o_frame_err  out  1  one-cycle pulse on timeout or dropped byte

## Operation
- Opcodes (first byte): 0xAA write {addr, data}; 0xBB read {addr}; 0xCC ALU with operands {A, B, func}; 0xDD ALU without operands {func}. Any other first byte ignored, stays IDLE, no error.
- States: IDLE, GET_ADDR, GET_DATA, GET_OPA, GET_OPB, GET_FUNC, RF_WRITE, RF_READ, RF_WAIT, ALU_RUN, ALU_WAIT, PUSH_LO, PUSH_HI.
- Write: GET_ADDR→GET_DATA→RF_WRITE (wr_en pulse) →IDLE. No response.
- Read: GET_ADDR→RF_READ (rd_en pulse) →RF_WAIT until i_rf_rvalid→PUSH_LO (push rdata) →IDLE.
- 0xCC: GET_OPA→(RF_WRITE addr 0)→GET_OPB→(RF_WRITE addr 1)→GET_FUNC→ALU_RUN; 0xDD: GET_FUNC→ALU_RUN. ALU_RUN pulses o_alu_en with func latched; ALU_WAIT until i_alu_valid, result latched; PUSH_LO pushes result[WIDTH-1:0], PUSH_HI pushes result[2*WIDTH-1:WIDTH]; →IDLE.
- Bytes arriving in RF_*/ALU_*/PUSH_* states are dropped and pulse o_frame_err.
- PUSH_* stalls while FIFO full; push succeeds on a full FIFO when a pop occurs the same cycle.
- FIFO: head presented combinationally from storage; pop on o_tx_valid && i_tx_ready; pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.

## Timing
- Reset: state IDLE, FIFO empty, all outputs 0, latched fields 0. Reset mid-frame discards partial frame and FIFO contents.
- Byte accepted in the cycle i_rx_valid is high; next state effective next edge.
- Write strobe: 1 cycle after the data byte's strobe cycle; exactly one cycle wide.
- Read response: pushed the cycle after i_rf_rvalid; o_tx_valid high the following cycle.
- ALU: o_alu_en 1 cycle after func byte (2 cycles after OPB write for 0xCC); LO byte pushed cycle after i_alu_valid, HI next cycle (if not full).
- i_tx_ready with FIFO empty: no effect.

## Configuration
- SYS_CMD_TIMEOUT_EN defined: counter cleared on every accepted byte and on IDLE; in GET_* states reaching TIMEOUT_CYC-1 idle cycles forces IDLE and pulses o_frame_err. RF_WAIT/ALU_WAIT never time out.
- Undefined: no counter; incomplete frames wait indefinitely; o_frame_err only from dropped bytes.

## Structure
- Package system_cmd_pkg: opcode constants (CMD_WR, CMD_RD, CMD_ALU_OP, CMD_ALU_NOP), state encoding, default WIDTH/ADDR_W.
- Sub-module system_resp_fifo: single-clock FIFO (WIDTH, FIFO_DEPTH), push/pop/full/empty; FSM in the parent.

## Test plan
- Frame AA 03 5C → single o_rf_wr_en, addr 3, wdata 0x5C; FIFO stays empty.
- Frame BB 03, rdata 0x5C with rvalid 2 cycles after rd_en → o_tx_data 0x5C, o_tx_valid until ready.
- Frame CC 10 20 01, result 0x0230 → writes reg0=0x10, reg1=0x20, alu_en func 1, TX bytes 0x30 then 0x02.
- i_tx_ready held 0, five 0xDD frames with FIFO_DEPTH 8 → 8 bytes queued, FSM stalls in PUSH_LO, o_busy high; ready 1 → all 10 bytes drain in order.
- With SYS_CMD_TIMEOUT_EN, TIMEOUT_CYC 16: AA then silence → o_frame_err pulse after 16 cycles, IDLE; next frame AA 01 FF writes correctly.

Source files
------------

// File: rtl/system_cmd_pkg.sv
// Shared constants for the frame-level command controller: opcodes, FSM state
// encoding, frame-kind tags and default datapath widths.
package system_cmd_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 4;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [ST_W-1:0] ST_GET_ADDR = 4'd1;
  localparam logic [ST_W-1:0] ST_GET_DATA = 4'd2;
  localparam logic [ST_W-1:0] ST_GET_OPA  = 4'd3;
  localparam logic [ST_W-1:0] ST_GET_OPB  = 4'd4;
  localparam logic [ST_W-1:0] ST_GET_FUNC = 4'd5;
  localparam logic [ST_W-1:0] ST_RF_WRITE = 4'd6;
  localparam logic [ST_W-1:0] ST_RF_READ  = 4'd7;
  localparam logic [ST_W-1:0] ST_RF_WAIT  = 4'd8;
  localparam logic [ST_W-1:0] ST_ALU_RUN  = 4'd9;
  localparam logic [ST_W-1:0] ST_ALU_WAIT = 4'd10;
  localparam logic [ST_W-1:0] ST_PUSH_LO  = 4'd11;
  localparam logic [ST_W-1:0] ST_PUSH_HI  = 4'd12;

  // Tracks which frame is in flight so shared states know where to go next.
  typedef enum logic [2:0] {
    FR_NONE,
    FR_WR,
    FR_RD,
    FR_OPA,
    FR_OPB,
    FR_ALU
  } frame_e;

  function automatic logic is_get_state(input logic [ST_W-1:0] st);
    return (st == ST_GET_ADDR) || (st == ST_GET_DATA) || (st == ST_GET_OPA) ||
           (st == ST_GET_OPB)  || (st == ST_GET_FUNC);
  endfunction

endpackage

// File: rtl/system_cmd_ctrl_if.sv
// Bus bundle between the command controller and its environment (RX stream,
// register file, ALU, TX consumer). master = controller view, slave = environment.
interface system_cmd_ctrl_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4,
  parameter int FUNC_W = 4
);

  logic [WIDTH-1:0]   i_rx_data;
  logic               i_rx_valid;
  logic               o_rf_wr_en;
  logic               o_rf_rd_en;
  logic [ADDR_W-1:0]  o_rf_addr;
  logic [WIDTH-1:0]   o_rf_wdata;
  logic [WIDTH-1:0]   i_rf_rdata;
  logic               i_rf_rvalid;
  logic               o_alu_en;
  logic [FUNC_W-1:0]  o_alu_func;
  logic [2*WIDTH-1:0] i_alu_result;
  logic               i_alu_valid;
  logic [WIDTH-1:0]   o_tx_data;
  logic               o_tx_valid;
  logic               i_tx_ready;
  logic               o_busy;
  logic               o_frame_err;

  modport master (
    input  i_rx_data, i_rx_valid, i_rf_rdata, i_rf_rvalid,
           i_alu_result, i_alu_valid, i_tx_ready,
    output o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wdata, o_alu_en,
           o_alu_func, o_tx_data, o_tx_valid, o_busy, o_frame_err
  );

  modport slave (
    output i_rx_data, i_rx_valid, i_rf_rdata, i_rf_rvalid,
           i_alu_result, i_alu_valid, i_tx_ready,
    input  o_rf_wr_en, o_rf_rd_en, o_rf_addr, o_rf_wdata, o_alu_en,
           o_alu_func, o_tx_data, o_tx_valid, o_busy, o_frame_err
  );

endinterface

// File: rtl/system_resp_fifo.sv
// Single-clock response FIFO; head is read combinationally from storage and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module system_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag guards every read of stale data.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/system_cmd_ctrl.sv
// Frame-level command controller: parses RX command frames, sequences RF/ALU
// operations and queues response bytes. Optional frame timeout: SYS_CMD_TIMEOUT_EN.
module system_cmd_ctrl
  import system_cmd_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 1024,
  parameter int FUNC_W      = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  system_cmd_ctrl_if.master bus
);

  logic [ST_W-1:0]    state_q, state_d;
  frame_e             frame_q, frame_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [FUNC_W-1:0]  func_q, func_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               frame_err_q, frame_err_d;

  logic               push_req, push_ok, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0]   push_data, fifo_head;
  logic               drop, timeout;
  logic               rx;
  logic [WIDTH-1:0]   rx_byte;

  assign rx      = bus.i_rx_valid;
  assign rx_byte = bus.i_rx_data;

  assign fifo_pop = !fifo_empty && bus.i_tx_ready;
  assign push_ok  = push_req && (!fifo_full || fifo_pop);

  // Bytes are only meaningful in IDLE and GET_*; anywhere else they are lost.
  assign drop = rx && (state_q != ST_IDLE) && !is_get_state(state_q);

`ifdef SYS_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (is_get_state(state_q) && !rx) begin
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) timeout  = 1'b1;
      else                                    to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    addr_d      = addr_q;
    data_d      = data_q;
    func_d      = func_q;
    res_d       = res_q;
    push_req    = 1'b0;
    push_data   = res_q[WIDTH-1:0];
    frame_err_d = drop || timeout;

    case (state_q)
      ST_IDLE: begin
        if (rx) begin
          case (rx_byte)
            WIDTH'(CMD_WR):      begin frame_d = FR_WR;  state_d = ST_GET_ADDR; end
            WIDTH'(CMD_RD):      begin frame_d = FR_RD;  state_d = ST_GET_ADDR; end
            WIDTH'(CMD_ALU_OP):  begin frame_d = FR_OPA; state_d = ST_GET_OPA;  end
            WIDTH'(CMD_ALU_NOP): begin frame_d = FR_ALU; state_d = ST_GET_FUNC; end
            default: ;
          endcase
        end
      end
      ST_GET_ADDR: begin
        if (rx) begin
          addr_d  = rx_byte[ADDR_W-1:0];
          state_d = (frame_q == FR_WR) ? ST_GET_DATA : ST_RF_READ;
        end
      end
      ST_GET_DATA: begin
        if (rx) begin
          data_d  = rx_byte;
          state_d = ST_RF_WRITE;
        end
      end
      ST_GET_OPA: begin
        if (rx) begin
          addr_d  = '0;
          data_d  = rx_byte;
          state_d = ST_RF_WRITE;
        end
      end
      ST_GET_OPB: begin
        if (rx) begin
          addr_d  = ADDR_W'(1);
          data_d  = rx_byte;
          state_d = ST_RF_WRITE;
        end
      end
      ST_GET_FUNC: begin
        if (rx) begin
          func_d  = rx_byte[FUNC_W-1:0];
          state_d = ST_ALU_RUN;
        end
      end
      // Operand writes of an ALU frame return to the parser for the next field.
      ST_RF_WRITE: begin
        case (frame_q)
          FR_OPA:  begin frame_d = FR_OPB; state_d = ST_GET_OPB;  end
          FR_OPB:  begin frame_d = FR_ALU; state_d = ST_GET_FUNC; end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_RF_READ: state_d = ST_RF_WAIT;
      ST_RF_WAIT: begin
        if (bus.i_rf_rvalid) begin
          res_d   = {{WIDTH{1'b0}}, bus.i_rf_rdata};
          state_d = ST_PUSH_LO;
        end
      end
      ST_ALU_RUN: state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: begin
        if (bus.i_alu_valid) begin
          res_d   = bus.i_alu_result;
          state_d = ST_PUSH_LO;
        end
      end
      ST_PUSH_LO: begin
        push_req = 1'b1;
        if (push_ok) state_d = (frame_q == FR_RD) ? ST_IDLE : ST_PUSH_HI;
      end
      ST_PUSH_HI: begin
        push_req  = 1'b1;
        push_data = res_q[2*WIDTH-1:WIDTH];
        if (push_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout) begin
      state_d = ST_IDLE;
      frame_d = FR_NONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      frame_q     <= FR_NONE;
      addr_q      <= '0;
      data_q      <= '0;
      func_q      <= '0;
      res_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      func_q      <= func_d;
      res_q       <= res_d;
      frame_err_q <= frame_err_d;
    end
  end

  system_resp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (i_clk),
    .rst_n (i_rst),
    .push  (push_ok),
    .wdata (push_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.o_rf_wr_en  = (state_q == ST_RF_WRITE);
  assign bus.o_rf_rd_en  = (state_q == ST_RF_READ);
  assign bus.o_rf_addr   = addr_q;
  assign bus.o_rf_wdata  = data_q;
  assign bus.o_alu_en    = (state_q == ST_ALU_RUN);
  assign bus.o_alu_func  = func_q;
  assign bus.o_tx_data   = fifo_head;
  assign bus.o_tx_valid  = !fifo_empty;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_system_cmd_ctrl.sv
// Scoreboard bench for system_cmd_ctrl: behavioural RF/ALU responders, expected
// writes/funcs/TX bytes queued at stimulus time and checked as the DUT produces them.
module tb_system_cmd_ctrl;

  localparam int WIDTH       = 8;
  localparam int ADDR_W      = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int FUNC_W      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  system_cmd_ctrl_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .FUNC_W(FUNC_W)) bus ();

  system_cmd_ctrl #(
    .WIDTH       (WIDTH),
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FUNC_W      (FUNC_W)
  ) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_cycles = 0;
  int exp_err    = 0;

  logic [7:0]  tx_exp[$];
  logic [11:0] wr_exp[$];
  logic [3:0]  func_exp[$];
  logic [7:0]  exp_rf [16];
  logic [7:0]  tb_rf  [16];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
    case (f)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return ({8'h00, a} * {8'h00, b}) + {8'h00, a} + {8'h00, b};
      4'd2:    return {8'h00, a} - {8'h00, b};
      default: return {a, b};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data  = b;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
  endtask

  task automatic wr_frame(input logic [3:0] a, input logic [7:0] d);
    wr_exp.push_back({a, d});
    exp_rf[a] = d;
    send_byte(8'hAA); tick();
    send_byte({4'h0, a}); tick();
    send_byte(d);
  endtask

  task automatic rd_frame(input logic [3:0] a);
    tx_exp.push_back(exp_rf[a]);
    send_byte(8'hBB); tick();
    send_byte({4'h0, a});
  endtask

  task automatic alu_op_frame(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    logic [15:0] r;
    r = alu_model(a, b, f);
    wr_exp.push_back({4'd0, a});
    wr_exp.push_back({4'd1, b});
    exp_rf[0] = a;
    exp_rf[1] = b;
    func_exp.push_back(f);
    tx_exp.push_back(r[7:0]);
    tx_exp.push_back(r[15:8]);
    send_byte(8'hCC); tick();
    send_byte(a); tick();
    send_byte(b); tick();
    send_byte({4'h0, f});
  endtask

  task automatic alu_nop_frame(input logic [3:0] f);
    logic [15:0] r;
    r = alu_model(exp_rf[0], exp_rf[1], f);
    func_exp.push_back(f);
    tx_exp.push_back(r[7:0]);
    tx_exp.push_back(r[15:8]);
    send_byte(8'hDD); tick();
    send_byte({4'h0, f});
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.o_busy) break;
    end
    check(tag, bus.o_busy, 1'b0);
    tick();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 60 && tx_exp.size() != 0; i++) tick();
    check(tag, tx_exp.size(), 0);
  endtask

  // Monitor: register writes, ALU starts, TX handshakes, error pulses.
  logic [11:0] wr_e;
  logic [7:0]  tx_e;
  logic [3:0]  f_e;
  always @(negedge clk) begin
    if (bus.o_rf_wr_en) begin
      tb_rf[bus.o_rf_addr] = bus.o_rf_wdata;
      if (wr_exp.size() == 0) check("wr_unexpected", 1'b1, 1'b0);
      else begin
        wr_e = wr_exp.pop_front();
        check("wr_addr", bus.o_rf_addr, wr_e[11:8]);
        check("wr_data", bus.o_rf_wdata, wr_e[7:0]);
      end
    end
    if (bus.o_alu_en) begin
      if (func_exp.size() == 0) check("alu_unexpected", 1'b1, 1'b0);
      else begin
        f_e = func_exp.pop_front();
        check("alu_func", bus.o_alu_func, f_e);
      end
    end
    if (bus.o_tx_valid && bus.i_tx_ready) begin
      if (tx_exp.size() == 0) check("tx_unexpected", 1'b1, 1'b0);
      else begin
        tx_e = tx_exp.pop_front();
        check("tx_byte", bus.o_tx_data, tx_e);
      end
    end
    if (bus.o_frame_err) err_cycles++;
  end

  // Register-file read responder: data valid two cycles after the read strobe.
  initial begin
    logic [3:0] ra;
    bus.i_rf_rvalid = 1'b0;
    bus.i_rf_rdata  = '0;
    forever begin
      @(negedge clk);
      if (bus.o_rf_rd_en) begin
        ra = bus.o_rf_addr;
        tick(); tick();
        bus.i_rf_rvalid = 1'b1;
        bus.i_rf_rdata  = tb_rf[ra];
        tick();
        bus.i_rf_rvalid = 1'b0;
        bus.i_rf_rdata  = '0;
      end
    end
  end

  // ALU responder: operands from registers 0/1, result three cycles after start.
  initial begin
    logic [3:0] af;
    logic [7:0] aa, ab;
    bus.i_alu_valid  = 1'b0;
    bus.i_alu_result = '0;
    forever begin
      @(negedge clk);
      if (bus.o_alu_en) begin
        af = bus.o_alu_func;
        aa = tb_rf[0];
        ab = tb_rf[1];
        repeat (3) tick();
        bus.i_alu_valid  = 1'b1;
        bus.i_alu_result = alu_model(aa, ab, af);
        tick();
        bus.i_alu_valid  = 1'b0;
        bus.i_alu_result = '0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      exp_rf[i] = '0;
      tb_rf[i]  = '0;
    end
    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_busy",      bus.o_busy,      1'b0);
    check("rst_tx_valid",  bus.o_tx_valid,  1'b0);
    check("rst_wr_en",     bus.o_rf_wr_en,  1'b0);
    check("rst_rd_en",     bus.o_rf_rd_en,  1'b0);
    check("rst_alu_en",    bus.o_alu_en,    1'b0);
    check("rst_frame_err", bus.o_frame_err, 1'b0);
    check("rst_rf_addr",   bus.o_rf_addr,   4'h0);
    check("rst_rf_wdata",  bus.o_rf_wdata,  8'h00);
    check("rst_alu_func",  bus.o_alu_func,  4'h0);
    rst_n = 1'b1;
    tick();

    // Write frame AA 03 5C: single strobe the cycle after the data byte.
    wr_frame(4'd3, 8'h5C);
    @(negedge clk);
    check("wr_strobe_timing", bus.o_rf_wr_en, 1'b1);
    @(negedge clk);
    check("wr_strobe_width", bus.o_rf_wr_en, 1'b0);
    tick();
    wait_idle("wr_idle");
    check("wr_no_response", bus.o_tx_valid, 1'b0);

    // Read frame BB 03: response held until the consumer is ready.
    rd_frame(4'd3);
    n = 0;
    while (!bus.o_tx_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rd_tx_valid", bus.o_tx_valid, 1'b1);
    check("rd_tx_data",  bus.o_tx_data,  8'h5C);
    repeat (3) @(negedge clk);
    check("rd_tx_hold", bus.o_tx_valid, 1'b1);
    tick();
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_tx_ready = 1'b0;
    @(negedge clk);
    check("rd_tx_popped", bus.o_tx_valid, 1'b0);
    tick();
    wait_idle("rd_idle");

    // ALU with operands CC 10 20 01 -> 0x0230, LO byte first.
    bus.i_tx_ready = 1'b1;
    alu_op_frame(8'h10, 8'h20, 4'd1);
    @(negedge clk);
    check("alu_en_timing", bus.o_alu_en, 1'b1);
    tick();
    wait_idle("alu_op_idle");
    wait_drain("alu_op_drain");

    // Unknown opcode is ignored; ready on an empty FIFO has no effect.
    send_byte(8'h55);
    @(negedge clk);
    check("bad_opcode_idle", bus.o_busy, 1'b0);
    check("empty_ready_no_valid", bus.o_tx_valid, 1'b0);
    tick();

    // Byte arriving during ALU_RUN is dropped with an error pulse.
    alu_nop_frame(4'd0);
    send_byte(8'h77);
    exp_err++;
    wait_idle("drop_idle");
    wait_drain("drop_drain");

    // Five 0xDD frames with the consumer stalled: FIFO fills, FSM stalls.
    bus.i_tx_ready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      alu_nop_frame(4'(f));
      wait_idle("fill_idle");
    end
    alu_nop_frame(4'd4);
    repeat (20) tick();
    check("full_stall_busy",  bus.o_busy,     1'b1);
    check("full_stall_valid", bus.o_tx_valid, 1'b1);
    bus.i_tx_ready = 1'b1;
    wait_idle("full_release_idle");
    wait_drain("full_drain");

    // Reset mid-frame discards the partial frame and queued bytes.
    bus.i_tx_ready = 1'b0;
    alu_nop_frame(4'd2);
    wait_idle("pre_reset_idle");
    send_byte(8'hAA); tick();
    send_byte(8'h05);
    rst_n = 1'b0;
    tx_exp.delete();
    tick();
    check("midrst_busy",  bus.o_busy,     1'b0);
    check("midrst_valid", bus.o_tx_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    wr_frame(4'd1, 8'hFF);
    tick();
    wait_idle("post_reset_wr_idle");
    bus.i_tx_ready = 1'b1;
    rd_frame(4'd1);
    tick();
    wait_idle("post_reset_rd_idle");
    wait_drain("post_reset_drain");

`ifdef SYS_CMD_TIMEOUT_EN
    // Incomplete frame is abandoned after the idle timeout.
    send_byte(8'hAA);
    n = 0;
    while (!bus.o_frame_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    exp_err++;
    check("timeout_pulse", bus.o_frame_err, 1'b1);
    check("timeout_latency", (n >= TIMEOUT_CYC - 1) && (n <= TIMEOUT_CYC + 2), 1'b1);
    check("timeout_idle", bus.o_busy, 1'b0);
    tick();
    wr_frame(4'd1, 8'hFF);
    tick();
    wait_idle("timeout_wr_idle");
    rd_frame(4'd1);
    tick();
    wait_idle("timeout_rd_idle");
    wait_drain("timeout_drain");
`endif

    repeat (5) tick();
    check("err_pulse_count", err_cycles, exp_err);
    check("wr_all_seen",  wr_exp.size(),   0);
    check("alu_all_seen", func_exp.size(), 0);
    check("tx_all_seen",  tx_exp.size(),   0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
